// File: rtl/bp_fpga_host_pkg.sv
// Shared NBF packet layout for the FPGA host: field widths, packed packet
// struct and the derived byte counts of the serial wire format.
package bp_fpga_host_pkg;

  localparam int nbf_opcode_width_gp = 8;
  localparam int nbf_addr_width_gp   = 40;
  localparam int nbf_data_width_gp   = 64;
  localparam int nbf_width_gp        = nbf_opcode_width_gp + nbf_addr_width_gp + nbf_data_width_gp;

  localparam int nbf_addr_bytes_gp   = nbf_addr_width_gp / 8;
  localparam int nbf_data_bytes_gp   = nbf_data_width_gp / 8;
  localparam int nbf_bytes_gp        = 1 + nbf_addr_bytes_gp + nbf_data_bytes_gp;

  typedef struct packed {
    logic [nbf_opcode_width_gp-1:0] opcode;
    logic [nbf_addr_width_gp-1:0]   addr;
    logic [nbf_data_width_gp-1:0]   data;
  } bp_fpga_host_nbf_s;

  // One opcode byte followed by the address and data bytes.
  function automatic int nbf_byte_count(input int addr_w, input int data_w);
    return 1 + addr_w / 8 + data_w / 8;
  endfunction

endpackage

// File: rtl/bp_fpga_host_nbf_deserializer_idle_ctr.sv
// Idle-cycle counter for the NBF deserializer: clear has priority over count,
// and the count saturates at all-ones instead of wrapping.
module bp_fpga_host_nbf_deserializer_idle_ctr
  import bp_fpga_host_pkg::*;
#(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i || clear_i) begin
      count_o <= '0;
    end else if (up_i && !(&count_o)) begin
      count_o <= count_o + 1'b1;
    end
  end

endmodule

// File: rtl/bp_fpga_host_nbf_deserializer.sv
// Assembles 14-byte NBF packets from the UART rx byte stream and hands them to
// the IO-in stage; partial packets are dropped on idle timeout or rx error.
module bp_fpga_host_nbf_deserializer
  import bp_fpga_host_pkg::*;
#(
  parameter int nbf_opcode_width_p = 8,
  parameter int nbf_addr_width_p   = 40,
  parameter int nbf_data_width_p   = 64,
  parameter int uart_data_bits_p   = 8,
  parameter int timeout_cycles_p   = 30000,
  parameter int drop_count_width_p = 8,
  localparam int nbf_width_lp = nbf_opcode_width_p + nbf_addr_width_p + nbf_data_width_p
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,

  input  logic [uart_data_bits_p-1:0]   rx_i,
  input  logic                          rx_v_i,
  output logic                          rx_yumi_o,
  input  logic                          rx_parity_error_i,
  input  logic                          rx_frame_error_i,
  input  logic                          rx_overflow_error_i,

  output logic [nbf_width_lp-1:0]       nbf_o,
  output logic                          nbf_v_o,
  input  logic                          nbf_ready_and_i,

  output logic [2:0]                    error_o,
  output logic [drop_count_width_p-1:0] drop_count_o
);

  localparam int addr_bytes_lp   = nbf_addr_width_p / 8;
  localparam int nbf_bytes_lp    = nbf_byte_count(nbf_addr_width_p, nbf_data_width_p);
  localparam int byte_cnt_w_lp   = $clog2(nbf_bytes_lp);
  localparam int idle_w_lp       = $clog2(timeout_cycles_p + 1);

  localparam logic [byte_cnt_w_lp-1:0] last_byte_lp  = byte_cnt_w_lp'(nbf_bytes_lp - 1);
  localparam logic [idle_w_lp-1:0]     idle_limit_lp = idle_w_lp'(timeout_cycles_p - 1);

  typedef enum logic {e_fill, e_send} state_e;

  state_e                   state_q, state_n;
  logic [byte_cnt_w_lp-1:0] byte_cnt_q, byte_cnt_n;
  logic [idle_w_lp-1:0]     idle_cnt;
  logic                     idle_clr, idle_up;
  logic                     byte_wr, drop;
  logic [nbf_width_lp-1:0]  pkt_q;
  logic [2:0]               error_q;
  logic [drop_count_width_p-1:0] drop_q;
  logic                     rx_err;

  // Wire byte index -> LSB of its slot in {opcode, addr, data}.
  function automatic int slot_lsb(input logic [byte_cnt_w_lp-1:0] idx);
    int i;
    i = int'(idx);
    if (i == 0)                  return nbf_data_width_p + nbf_addr_width_p;
    else if (i <= addr_bytes_lp) return nbf_data_width_p + 8 * (i - 1);
    else                         return 8 * (i - 1 - addr_bytes_lp);
  endfunction

  function automatic logic [drop_count_width_p-1:0] sat_inc(input logic [drop_count_width_p-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign rx_err = rx_parity_error_i | rx_frame_error_i | rx_overflow_error_i;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) state_q <= e_fill;
    else            state_q <= state_n;
  end

  always_comb begin
    state_n    = state_q;
    byte_cnt_n = byte_cnt_q;
    rx_yumi_o  = 1'b0;
    nbf_v_o    = 1'b0;
    byte_wr    = 1'b0;
    idle_clr   = 1'b0;
    idle_up    = 1'b0;
    drop       = 1'b0;
    case (state_q)
      e_fill: begin
        rx_yumi_o = rx_v_i & reset_n_i;
        if (rx_err) begin
          // A byte landing in the error cycle is swallowed with the partial packet.
          drop       = rx_yumi_o | (byte_cnt_q != '0);
          byte_cnt_n = '0;
          idle_clr   = 1'b1;
        end else if (rx_yumi_o) begin
          byte_wr  = 1'b1;
          idle_clr = 1'b1;
          if (byte_cnt_q == last_byte_lp) begin
            byte_cnt_n = '0;
            state_n    = e_send;
          end else begin
            byte_cnt_n = byte_cnt_q + 1'b1;
          end
        end else if (byte_cnt_q != '0) begin
          if (idle_cnt == idle_limit_lp) begin
            drop       = 1'b1;
            byte_cnt_n = '0;
            idle_clr   = 1'b1;
          end else begin
            idle_up = 1'b1;
          end
        end else begin
          idle_clr = 1'b1;
        end
      end
      e_send: begin
        nbf_v_o = 1'b1;
        if (nbf_ready_and_i) state_n = e_fill;
      end
      default: state_n = e_fill;
    endcase
  end

  bp_fpga_host_nbf_deserializer_idle_ctr #(
    .width_p(idle_w_lp)
  ) idle_ctr (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .clear_i  (idle_clr),
    .up_i     (idle_up),
    .count_o  (idle_cnt)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      byte_cnt_q <= '0;
      pkt_q      <= '0;
      error_q    <= '0;
      drop_q     <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_n;
      error_q    <= error_q | {rx_overflow_error_i, rx_frame_error_i, rx_parity_error_i};
      if (byte_wr) pkt_q[slot_lsb(byte_cnt_q) +: uart_data_bits_p] <= rx_i;
      if (drop)    drop_q <= sat_inc(drop_q);
    end
  end

  assign nbf_o        = pkt_q;
  assign error_o      = error_q;
  assign drop_count_o = drop_q;

  a_nbf_stable: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (nbf_v_o && !nbf_ready_and_i) |=> $stable(nbf_o));

  a_yumi_v: assert property (@(posedge clk_i) rx_yumi_o |-> rx_v_i);

endmodule

// File: tb/tb_bp_fpga_host_nbf_deserializer.sv
// Directed bench for the NBF deserializer with a queue-based packet model
// checked every cycle plus literal checks on decoded packets and counters.
module tb_bp_fpga_host_nbf_deserializer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   rx;
  logic         rx_v;
  logic         rx_yumi;
  logic         par_err, frm_err, ovf_err;
  logic [111:0] nbf;
  logic         nbf_v;
  logic         ready;
  logic [2:0]   error;
  logic [7:0]   drop_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bp_fpga_host_nbf_deserializer #(
    .timeout_cycles_p(16)
  ) dut (
    .clk_i              (clk),
    .reset_n_i          (rst_n),
    .rx_i               (rx),
    .rx_v_i             (rx_v),
    .rx_yumi_o          (rx_yumi),
    .rx_parity_error_i  (par_err),
    .rx_frame_error_i   (frm_err),
    .rx_overflow_error_i(ovf_err),
    .nbf_o              (nbf),
    .nbf_v_o            (nbf_v),
    .nbf_ready_and_i    (ready),
    .error_o            (error),
    .drop_count_o       (drop_count)
  );

  task automatic chk(input string nm, input logic [111:0] act, input logic [111:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Spec-level model: bytes collected so far, held packet, sticky flags, drops.
  bit           m_valid = 0;
  bit           m_hold  = 0;
  logic [111:0] m_pkt   = '0;
  logic [7:0]   m_q[$];
  int           m_idle  = 0;
  logic [2:0]   m_err   = '0;
  int           m_drop  = 0;
  int           pkt_count = 0;
  logic [111:0] last_pkt  = '0;

  function automatic logic [111:0] pack_bytes();
    logic [39:0] a;
    logic [63:0] d;
    a = '0;
    d = '0;
    for (int i = 0; i < 5; i++) a = a | (40'(m_q[1+i]) << (8 * i));
    for (int i = 0; i < 8; i++) d = d | (64'(m_q[6+i]) << (8 * i));
    return {m_q[0], a, d};
  endfunction

  task automatic model_drop();
    if (m_drop < 255) m_drop++;
    m_q.delete();
    m_idle = 0;
  endtask

  task automatic model_step();
    logic exp_yumi;
    if (m_valid) begin
      exp_yumi = rst_n && !m_hold && rx_v;
      chk("yumi", 112'(rx_yumi), 112'(exp_yumi));
      chk("nbf_v", 112'(nbf_v), 112'(m_hold));
      chk("error", 112'(error), 112'(m_err));
      chk("drop_count", 112'(drop_count), 112'(m_drop));
      if (m_hold) chk("nbf", nbf, m_pkt);
      if (nbf_v && ready && rst_n) begin
        pkt_count++;
        last_pkt = nbf;
      end
    end
    if (!rst_n) begin
      m_valid = 1;
      m_hold  = 0;
      m_pkt   = '0;
      m_q.delete();
      m_idle  = 0;
      m_err   = '0;
      m_drop  = 0;
    end else if (m_valid) begin
      m_err = m_err | {ovf_err, frm_err, par_err};
      if (m_hold) begin
        if (ready) m_hold = 0;
      end else if (par_err || frm_err || ovf_err) begin
        if (rx_v || m_q.size() > 0) model_drop();
        else m_idle = 0;
      end else if (rx_v) begin
        m_q.push_back(rx);
        m_idle = 0;
        if (m_q.size() == 14) begin
          m_pkt  = pack_bytes();
          m_hold = 1;
          m_q.delete();
        end
      end else if (m_q.size() > 0) begin
        m_idle++;
        if (m_idle == 16) model_drop();
      end
    end
  endtask

  logic [7:0] pbytes[14];

  task automatic build(input logic [7:0] op, input logic [39:0] a, input logic [63:0] d);
    pbytes[0] = op;
    for (int i = 0; i < 5; i++) pbytes[1+i] = a[8*i +: 8];
    for (int i = 0; i < 8; i++) pbytes[6+i] = d[8*i +: 8];
  endtask

  task automatic idle(input int n);
    rx_v = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_range(input int lo, input int hi);
    logic got;
    for (int i = lo; i <= hi; i++) begin
      rx_v = 1'b1;
      rx   = pbytes[i];
      got  = 1'b0;
      for (int t = 0; t < 50 && !got; t++) begin
        @(negedge clk);
        got = rx_yumi;
        @(posedge clk);
        #1;
      end
      if (!got) chk("send_timeout", 112'(got), 112'(1));
    end
  endtask

  localparam logic [111:0] pkt1 = 112'h03_0030201000_8877665544332211;
  localparam logic [111:0] pkt2 = 112'h01_123456789A_DEADBEEF01234567;
  localparam logic [111:0] pkt3 = 112'h02_0000000040_0102030405060708;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; rx = '0; rx_v = 1'b0;
    par_err = 1'b0; frm_err = 1'b0; ovf_err = 1'b0; ready = 1'b1;
    fork
      forever begin
        @(negedge clk);
        model_step();
      end
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk("rst_nbf", nbf, '0);
    chk("rst_nbf_v", 112'(nbf_v), 112'(0));
    chk("rst_yumi", 112'(rx_yumi), 112'(0));
    chk("rst_error", 112'(error), 112'(0));
    chk("rst_drop", 112'(drop_count), 112'(0));
    rst_n = 1'b1;
    idle(2);

    // basic packet, consumer always ready
    build(8'h03, 40'h0030201000, 64'h8877665544332211);
    send_range(0, 13);
    idle(3);
    chk("p1_count", 112'(pkt_count), 112'(1));
    chk("p1_pkt", last_pkt, pkt1);

    // consumer stalls 20 cycles while the rx FIFO keeps offering a byte
    ready = 1'b0;
    build(8'h01, 40'h123456789A, 64'hDEADBEEF01234567);
    send_range(0, 13);
    rx = 8'hEE;
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    chk("p2_held_v", 112'(nbf_v), 112'(1));
    chk("p2_held", nbf, pkt2);
    rx_v = 1'b0;
    ready = 1'b1;
    idle(3);
    chk("p2_count", 112'(pkt_count), 112'(2));
    chk("p2_pkt", last_pkt, pkt2);

    // idle timeout drops a 6-byte partial, then a 15-cycle gap is tolerated
    build(8'h02, 40'h0000000040, 64'h0102030405060708);
    send_range(0, 5);
    idle(16);
    chk("to_drop", 112'(drop_count), 112'(1));
    chk("to_count", 112'(pkt_count), 112'(2));
    send_range(0, 13);
    idle(2);
    chk("to_pkt", last_pkt, pkt3);
    send_range(0, 5);
    idle(15);
    send_range(6, 13);
    idle(2);
    chk("gap_count", 112'(pkt_count), 112'(4));
    chk("gap_drop", 112'(drop_count), 112'(1));
    chk("gap_pkt", last_pkt, pkt3);

    // frame error after 9 bytes
    build(8'h03, 40'h0030201000, 64'h8877665544332211);
    send_range(0, 8);
    rx_v = 1'b0;
    frm_err = 1'b1;
    @(posedge clk);
    #1;
    frm_err = 1'b0;
    idle(1);
    chk("fe_error", 112'(error), 112'(3'b010));
    chk("fe_drop", 112'(drop_count), 112'(2));
    send_range(0, 13);
    idle(2);
    chk("fe_count", 112'(pkt_count), 112'(5));
    chk("fe_pkt", last_pkt, pkt1);
    chk("fe_sticky", 112'(error), 112'(3'b010));

    // parity error on the final byte suppresses the packet
    send_range(0, 12);
    rx_v = 1'b1;
    rx = pbytes[13];
    par_err = 1'b1;
    @(posedge clk);
    #1;
    par_err = 1'b0;
    idle(3);
    chk("pe13_count", 112'(pkt_count), 112'(5));
    chk("pe13_drop", 112'(drop_count), 112'(3));
    chk("pe13_error", 112'(error), 112'(3'b011));

    // overflow error while a packet is held still delivers it
    ready = 1'b0;
    build(8'h02, 40'h0000000040, 64'h0102030405060708);
    send_range(0, 13);
    idle(2);
    ovf_err = 1'b1;
    @(posedge clk);
    #1;
    ovf_err = 1'b0;
    idle(2);
    ready = 1'b1;
    idle(2);
    chk("send_err_count", 112'(pkt_count), 112'(6));
    chk("send_err_pkt", last_pkt, pkt3);
    chk("send_err_error", 112'(error), 112'(3'b111));
    chk("send_err_drop", 112'(drop_count), 112'(3));

    // 300 error+byte cycles saturate the drop counter
    rx_v = 1'b1;
    rx = 8'h55;
    par_err = 1'b1;
    repeat (300) begin
      @(posedge clk);
      #1;
    end
    par_err = 1'b0;
    idle(2);
    chk("sat_drop", 112'(drop_count), 112'(255));

    // reset mid-fill discards everything
    build(8'h01, 40'h123456789A, 64'hDEADBEEF01234567);
    send_range(0, 4);
    rx_v = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("mid_rst_nbf", nbf, '0);
    chk("mid_rst_error", 112'(error), 112'(0));
    chk("mid_rst_drop", 112'(drop_count), 112'(0));
    chk("mid_rst_v", 112'(nbf_v), 112'(0));
    idle(2);
    send_range(0, 13);
    idle(3);
    chk("post_rst_count", 112'(pkt_count), 112'(7));
    chk("post_rst_pkt", last_pkt, pkt2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
